// File: rtl/output_acc_buffer.sv
// Partial-sum buffer: DEPTH entries of LANES signed lanes, overwrite or saturating-add writes.
// Latency: writes land at the next edge; a drain's first beat is valid one cycle after the start edge.
// Backpressure: the output register holds its beat while out_rdy_i is low; the drain pointer stalls with it.
module output_acc_buffer #(
    parameter int DATA_W = 16,
    parameter int LANES  = 8,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int EW    = LANES * DATA_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          acc_val_i,
    input  logic [AW-1:0] acc_sel_i,
    input  logic          acc_mode_i,
    input  logic [EW-1:0] acc_dat_i,
    output logic [EW-1:0] acc_dat_o,
    input  logic          drain_start_i,
    input  logic [AW-1:0] drain_base_i,
    input  logic [AW-1:0] drain_len_i,
    input  logic          drain_clr_i,
    output logic          drain_busy_o,
    output logic          drain_done_o,
    output logic          out_val_o,
    input  logic          out_rdy_i,
    output logic [EW-1:0] out_dat_o,
    output logic [AW-1:0] out_idx_o,
    output logic          out_last_o,
    output logic          ovf_o,
    input  logic          ovf_clr_i
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [EW-1:0]    mem [DEPTH];
    logic [1:0]       state;
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    rem;
    logic             clr_q;

    logic             load;
    logic             hshk;
    logic             clr_hit;
    logic [EW-1:0]    old_ent;
    logic [EW-1:0]    sum_ent;
    logic [EW-1:0]    wr_ent;
    logic [LANES-1:0] lane_ovf;
    logic             wr_sat;

    assign load      = (state == ST_DRAIN) && (!out_val_o || out_rdy_i);
    assign hshk      = out_val_o && out_rdy_i;
    assign acc_dat_o = mem[acc_sel_i];

    // An entry being cleared by the drain this edge reads as zero to a colliding add.
    assign clr_hit   = load && clr_q && (ptr == acc_sel_i);
    assign old_ent   = clr_hit ? '0 : mem[acc_sel_i];

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W:0]   s;
        assign a           = old_ent[k*DATA_W +: DATA_W];
        assign b           = acc_dat_i[k*DATA_W +: DATA_W];
        assign s           = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        assign lane_ovf[k] = s[DATA_W] ^ s[DATA_W-1];
        assign sum_ent[k*DATA_W +: DATA_W] =
            !lane_ovf[k] ? s[DATA_W-1:0] :
            s[DATA_W]    ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end

    assign wr_ent = acc_mode_i ? sum_ent : acc_dat_i;
    assign wr_sat = acc_val_i && acc_mode_i && (|lane_ovf);

    // Write is ordered after the drain clear so a colliding write wins.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (load && clr_q) begin
                mem[ptr] <= '0;
            end
            if (acc_val_i) begin
                mem[acc_sel_i] <= wr_ent;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ovf_o <= 1'b0;
        end else if (wr_sat) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            rem          <= '0;
            clr_q        <= 1'b0;
            out_val_o    <= 1'b0;
            out_dat_o    <= '0;
            out_idx_o    <= '0;
            out_last_o   <= 1'b0;
            drain_done_o <= 1'b0;
        end else begin
            drain_done_o <= 1'b0;
            if (state == ST_IDLE && drain_start_i) begin
                state <= ST_DRAIN;
                ptr   <= drain_base_i;
                rem   <= drain_len_i;
                clr_q <= drain_clr_i;
            end
            if (load) begin
                out_dat_o  <= mem[ptr];
                out_idx_o  <= ptr;
                out_last_o <= (rem == '0);
                out_val_o  <= 1'b1;
                ptr        <= ptr + 1'b1;
                rem        <= rem - 1'b1;
                if (rem == '0) begin
                    state <= ST_FLUSH;
                end
            end else if (hshk) begin
                out_val_o <= 1'b0;
            end
            // In FLUSH the only beat in flight is the final one.
            if (state == ST_FLUSH && hshk) begin
                state        <= ST_IDLE;
                drain_done_o <= 1'b1;
            end
        end
    end

    assign drain_busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_output_acc_buffer.sv
// Randomized bench for output_acc_buffer: lane-level integer model plus a beat scoreboard
// fed at drain start and drained by a monitor on every output handshake.
module tb_output_acc_buffer;

    localparam int DATA_W = 16;
    localparam int LANES  = 8;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int EW     = LANES * DATA_W;
    localparam int MAXV   = (1 << (DATA_W - 1)) - 1;
    localparam int MINV   = -(1 << (DATA_W - 1));

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          acc_val_i;
    logic [AW-1:0] acc_sel_i;
    logic          acc_mode_i;
    logic [EW-1:0] acc_dat_i;
    logic [EW-1:0] acc_dat_o;
    logic          drain_start_i;
    logic [AW-1:0] drain_base_i;
    logic [AW-1:0] drain_len_i;
    logic          drain_clr_i;
    logic          drain_busy_o;
    logic          drain_done_o;
    logic          out_val_o;
    logic          out_rdy_i;
    logic [EW-1:0] out_dat_o;
    logic [AW-1:0] out_idx_o;
    logic          out_last_o;
    logic          ovf_o;
    logic          ovf_clr_i;

    output_acc_buffer #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .acc_val_i(acc_val_i), .acc_sel_i(acc_sel_i), .acc_mode_i(acc_mode_i),
        .acc_dat_i(acc_dat_i), .acc_dat_o(acc_dat_o),
        .drain_start_i(drain_start_i), .drain_base_i(drain_base_i),
        .drain_len_i(drain_len_i), .drain_clr_i(drain_clr_i),
        .drain_busy_o(drain_busy_o), .drain_done_o(drain_done_o),
        .out_val_o(out_val_o), .out_rdy_i(out_rdy_i), .out_dat_o(out_dat_o),
        .out_idx_o(out_idx_o), .out_last_o(out_last_o),
        .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [EW-1:0] dat;
        int            idx;
        bit            last;
    } beat_t;

    beat_t exp_q[$];
    beat_t held;
    beat_t got;
    bit    held_v    = 1'b0;
    bit    pend_done = 1'b0;
    bit    mon_en    = 1'b0;
    int    rdy_mode  = 0;
    int    mdl [DEPTH][LANES];
    bit    mdl_ovf;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [EW-1:0] pack(input int e);
        logic [EW-1:0] r;
        int v;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            v = mdl[e][k];
            r[k*DATA_W +: DATA_W] = v[DATA_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [EW-1:0] rep(input int v);
        logic [EW-1:0] r;
        for (int k = 0; k < LANES; k++) r[k*DATA_W +: DATA_W] = v[DATA_W-1:0];
        return r;
    endfunction

    function automatic int lane_of(input logic [EW-1:0] d, input int k);
        logic signed [DATA_W-1:0] t;
        t = d[k*DATA_W +: DATA_W];
        return int'(t);
    endfunction

    function automatic logic [EW-1:0] rnd_dat();
        logic [EW-1:0] r;
        int v;
        for (int k = 0; k < LANES; k++) begin
            case ($urandom_range(0, 3))
                0: v = int'($urandom_range(0, 200)) - 100;
                1: v = int'($urandom_range(30000, 32767));
                2: v = -int'($urandom_range(30000, 32768));
                default: v = int'($urandom);
            endcase
            r[k*DATA_W +: DATA_W] = v[DATA_W-1:0];
        end
        return r;
    endfunction

    // One-cycle write; model applies the same rule as the spec in plain integer arithmetic.
    task automatic wr(input int sel, input bit mode, input logic [EW-1:0] dat, input bit oclr = 1'b0);
        int s;
        bit sat;
        acc_val_i  = 1'b1;
        acc_sel_i  = AW'(sel);
        acc_mode_i = mode;
        acc_dat_i  = dat;
        ovf_clr_i  = oclr;
        @(posedge clk_i); #1;
        acc_val_i = 1'b0;
        ovf_clr_i = 1'b0;
        sat = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            s = (mode ? mdl[sel][k] : 0) + lane_of(dat, k);
            if (s > MAXV) begin s = MAXV; sat = 1'b1; end
            if (s < MINV) begin s = MINV; sat = 1'b1; end
            mdl[sel][k] = s;
        end
        if (oclr) mdl_ovf = 1'b0;
        if (sat && mode) mdl_ovf = 1'b1;
    endtask

    task automatic ovf_clear();
        ovf_clr_i = 1'b1;
        @(posedge clk_i); #1;
        ovf_clr_i = 1'b0;
        mdl_ovf   = 1'b0;
    endtask

    task automatic chk_ent(input string nm, input int e);
        acc_sel_i = AW'(e);
        #1;
        chk(nm, acc_dat_o, pack(e));
    endtask

    task automatic drain_issue(input int base, input int len, input bit clr);
        beat_t b;
        int e;
        for (int i = 0; i <= len; i++) begin
            e      = (base + i) % DEPTH;
            b.dat  = pack(e);
            b.idx  = e;
            b.last = (i == len);
            exp_q.push_back(b);
        end
        if (clr) begin
            for (int i = 0; i <= len; i++) begin
                for (int k = 0; k < LANES; k++) mdl[(base + i) % DEPTH][k] = 0;
            end
        end
        drain_start_i = 1'b1;
        drain_base_i  = AW'(base);
        drain_len_i   = AW'(len);
        drain_clr_i   = clr;
        @(posedge clk_i); #1;
        drain_start_i = 1'b0;
    endtask

    task automatic drain_wait();
        int c;
        c = 0;
        while (drain_busy_o && c < 300) begin
            @(posedge clk_i); #1;
            c++;
        end
        chk("drain_end_busy", EW'(drain_busy_o), EW'(1'b0));
        repeat (2) begin @(posedge clk_i); #1; end
        chk("beats_outstanding", EW'(exp_q.size()), EW'(0));
    endtask

    initial begin
        out_rdy_i = 1'b0;
        forever begin
            @(posedge clk_i); #1;
            case (rdy_mode)
                0:       out_rdy_i = 1'b1;
                1:       out_rdy_i = ~out_rdy_i;
                2:       out_rdy_i = 1'($urandom_range(0, 1));
                default: out_rdy_i = 1'b0;
            endcase
        end
    end

    // Monitor: compares every handshaked beat against the scoreboard, checks stall stability and done.
    initial begin
        forever begin
            @(negedge clk_i);
            if (pend_done) begin
                pend_done = 1'b0;
                chk("done_pulse", EW'(drain_done_o), EW'(1'b1));
            end else if (drain_done_o) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_done: got 1 want 0");
            end
            if (mon_en && out_val_o) begin
                if (held_v) begin
                    chk("stall_dat", out_dat_o, held.dat);
                    chk("stall_idx", EW'(out_idx_o), EW'(held.idx));
                end
                if (out_rdy_i) begin
                    held_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL extra_beat: got idx %0d want none", out_idx_o);
                    end else begin
                        got = exp_q.pop_front();
                        chk("beat_dat", out_dat_o, got.dat);
                        chk("beat_idx", EW'(out_idx_o), EW'(got.idx));
                        chk("beat_last", EW'(out_last_o), EW'(got.last));
                        if (got.last) pend_done = 1'b1;
                    end
                end else begin
                    held_v    = 1'b1;
                    held.dat  = out_dat_o;
                    held.idx  = int'(out_idx_o);
                    held.last = out_last_o;
                end
            end
        end
    end

    initial begin
        int sel;
        rst_i = 1'b0;
        acc_val_i = 1'b0; acc_sel_i = '0; acc_mode_i = 1'b0; acc_dat_i = '0;
        drain_start_i = 1'b0; drain_base_i = '0; drain_len_i = '0; drain_clr_i = 1'b0;
        ovf_clr_i = 1'b0;
        mdl_ovf = 1'b0;
        for (int e = 0; e < DEPTH; e++) for (int k = 0; k < LANES; k++) mdl[e][k] = 0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_out_val", EW'(out_val_o), EW'(1'b0));
        chk("rst_busy", EW'(drain_busy_o), EW'(1'b0));
        chk("rst_ovf", EW'(ovf_o), EW'(1'b0));
        rst_i = 1'b1;
        for (int e = 0; e < DEPTH; e++) chk_ent("rst_entry", e);
        mon_en = 1'b1;

        wr(3, 0, rep(100));
        wr(3, 1, rep(50));
        wr(3, 1, rep(50));
        wr(3, 1, rep(50));
        chk_ent("acc_e3", 3);
        chk("acc_e3_const", acc_dat_o, rep(250));
        chk("acc_ovf", EW'(ovf_o), EW'(mdl_ovf));

        wr(0, 0, rep(32000));
        wr(0, 1, rep(1000));
        chk_ent("sat_pos", 0);
        chk("sat_pos_ovf", EW'(ovf_o), EW'(1'b1));
        ovf_clear();
        chk("ovf_clr", EW'(ovf_o), EW'(1'b0));
        wr(0, 0, rep(-32768));
        wr(0, 1, rep(-1));
        chk_ent("sat_neg", 0);
        chk("sat_neg_ovf", EW'(ovf_o), EW'(1'b1));
        ovf_clear();
        wr(0, 1, rep(-5), 1'b1);
        chk("ovf_set_wins", EW'(ovf_o), EW'(1'b1));
        ovf_clear();
        chk("ovf_clr2", EW'(ovf_o), EW'(mdl_ovf));

        foreach (exp_q[i]) exp_q.delete(i);
        wr(14, 0, rnd_dat()); wr(15, 0, rnd_dat()); wr(0, 0, rnd_dat()); wr(1, 0, rnd_dat());
        rdy_mode = 0;
        @(posedge clk_i); #1;
        drain_issue(14, 3, 1'b1);
        @(posedge clk_i); #1;
        chk("first_beat_latency", EW'(out_val_o), EW'(1'b1));
        drain_wait();
        chk_ent("clr_e14", 14); chk_ent("clr_e15", 15); chk_ent("clr_e0", 0); chk_ent("clr_e1", 1);

        wr(4, 0, rnd_dat()); wr(5, 0, rnd_dat()); wr(6, 0, rnd_dat());
        rdy_mode = 1;
        drain_issue(4, 2, 1'b0);
        drain_wait();

        wr(5, 0, rep(20));
        rdy_mode = 0;
        @(posedge clk_i); #1;
        drain_issue(5, 0, 1'b1);
        acc_val_i = 1'b1; acc_sel_i = AW'(5); acc_mode_i = 1'b1; acc_dat_i = rep(7);
        @(posedge clk_i); #1;
        acc_val_i = 1'b0;
        for (int k = 0; k < LANES; k++) mdl[5][k] = 7;
        drain_wait();
        chk_ent("clr_collision", 5);

        for (int it = 0; it < 40; it++) begin
            for (int w = 0; w < int'($urandom_range(1, 6)); w++) begin
                wr(int'($urandom_range(0, DEPTH - 1)), 1'($urandom_range(0, 1)), rnd_dat(),
                   ($urandom_range(0, 7) == 0));
            end
            chk("rnd_ovf", EW'(ovf_o), EW'(mdl_ovf));
            sel = int'($urandom_range(0, DEPTH - 1));
            chk_ent("rnd_entry", sel);
            if ($urandom_range(0, 3) == 0) ovf_clear();
            rdy_mode = int'($urandom_range(0, 2));
            drain_issue(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                        1'($urandom_range(0, 1)));
            drain_wait();
        end

        rdy_mode = 3;
        @(posedge clk_i); #1;
        drain_issue(2, 7, 1'b0);
        repeat (3) begin @(posedge clk_i); #1; end
        mon_en = 1'b0;
        rst_i  = 1'b0;
        #1;
        chk("rst_mid_val", EW'(out_val_o), EW'(1'b0));
        chk("rst_mid_busy", EW'(drain_busy_o), EW'(1'b0));
        exp_q.delete();
        held_v = 1'b0;
        mdl_ovf = 1'b0;
        for (int e = 0; e < DEPTH; e++) for (int k = 0; k < LANES; k++) mdl[e][k] = 0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        chk_ent("rst_mid_e2", 2);
        chk("rst_mid_ovf", EW'(ovf_o), EW'(1'b0));
        mon_en = 1'b1;
        rdy_mode = 0;
        wr(0, 0, rnd_dat());
        wr(1, 0, rnd_dat());
        drain_issue(0, 1, 1'b0);
        drain_wait();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
